demux4output16bit_reg: RTL and testbench

- Registered 1-to-4 demultiplexer: the distribution counterpart of the datapath's 4-input 16-bit selector.
- Accepts one WIDTH-bit word plus a 2-bit destination select under a valid/ready handshake.
- Holds each word in a per-destination output register until that destination's consumer acknowledges it.
- Sits between a single producer (ALU/write-back bus) and four consumers (register-file write ports, PC, memory data path).

---
 rtl/demux4output16bit_reg_pkg.sv | 8 +
 rtl/demux4output16bit_reg_chan.sv | 27 ++
 rtl/demux4output16bit_reg.sv | 57 +++++
 tb/tb_demux4output16bit_reg.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/demux4output16bit_reg_pkg.sv
// demux4output16bit_reg_pkg: shared datapath width and destination select encodings
package demux4output16bit_reg_pkg;
  localparam int DATA_W = 16;
  localparam logic [1:0] SEL_O0 = 2'd0;
  localparam logic [1:0] SEL_O1 = 2'd1;
  localparam logic [1:0] SEL_O2 = 2'd2;
  localparam logic [1:0] SEL_O3 = 2'd3;
endpackage

// File: rtl/demux4output16bit_reg_chan.sv
// demux_chan_reg: one-deep holding register with a full/empty bit
module demux_chan_reg
  import demux4output16bit_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             v
);
  // write beats pop; a pop alone only clears the valid bit, leaving q stale
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      v <= 1'b0;
    end else if (wr) begin
      q <= d;
      v <= 1'b1;
    end else if (pop) begin
      v <= 1'b0;
    end
  end
endmodule

// File: rtl/demux4output16bit_reg.sv
// demux4output16bit_reg: registered 1-to-4 demultiplexer with per-channel hold and broadcast
module demux4output16bit_reg
  import demux4output16bit_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  input  logic             BCAST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [3:0]       V,
  input  logic [3:0]       ACK,
  output logic [CNT_W-1:0] XFER_CNT
);
  logic [3:0]       sel_hot;
  logic [3:0]       free;
  logic [3:0]       wr;
  logic             accept;
  logic [WIDTH-1:0] q [4];

  assign sel_hot = {S == SEL_O3, S == SEL_O2, S == SEL_O1, S == SEL_O0};
  assign free = ~V | ACK;
  assign IN_READY = BCAST ? &free : |(free & sel_hot);
  assign accept = IN_VALID & IN_READY;
  assign wr = {4{accept}} & (BCAST ? 4'b1111 : sel_hot);

  for (genvar i = 0; i < 4; i++) begin : g_chan
    demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk (CLK),
      .rst (RST),
      .wr  (wr[i]),
      .pop (ACK[i]),
      .d   (D),
      .q   (q[i]),
      .v   (V[i])
    );
  end

  assign O0 = q[0];
  assign O1 = q[1];
  assign O2 = q[2];
  assign O3 = q[3];

  // one count per accepted offer, broadcast included; wraps silently
  always_ff @(posedge CLK) begin
    if (RST) XFER_CNT <= '0;
    else if (accept) XFER_CNT <= XFER_CNT + 1'b1;
  end
endmodule

// File: tb/tb_demux4output16bit_reg.sv
// tb_demux4output16bit_reg: directed self-checking bench for the registered 1-to-4 demux
module tb_demux4output16bit_reg;
  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] D;
  logic [1:0]  S;
  logic        BCAST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] O0, O1, O2, O3;
  logic [3:0]  V;
  logic [3:0]  ACK;
  logic [15:0] XFER_CNT;
  logic [15:0] o [4];
  int tests = 0;
  int failed = 0;

  demux4output16bit_reg dut (
    .CLK(CLK), .RST(RST), .D(D), .S(S), .BCAST(BCAST), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .O0(O0), .O1(O1), .O2(O2), .O3(O3), .V(V), .ACK(ACK),
    .XFER_CNT(XFER_CNT)
  );

  assign o[0] = O0;
  assign o[1] = O1;
  assign o[2] = O2;
  assign o[3] = O3;

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0]  vm;
    logic [3:0]  am;
    logic [15:0] cm;
    logic [15:0] dv;
    logic [1:0]  sv;
    RST = 1'b1; IN_VALID = 1'b1; D = 16'hBEEF; S = 2'd2; BCAST = 1'b0; ACK = 4'b0000;
    tick();
    tick();
    chk("rst_o0", 32'(O0), 32'h0);
    chk("rst_o1", 32'(O1), 32'h0);
    chk("rst_o2", 32'(O2), 32'h0);
    chk("rst_o3", 32'(O3), 32'h0);
    chk("rst_v", 32'(V), 32'h0);
    chk("rst_cnt", 32'(XFER_CNT), 32'h0);
    RST = 1'b0; IN_VALID = 1'b0;
    #1;
    chk("rst_ready", 32'(IN_READY), 32'h1);
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1; S = 2'(i); D = 16'(16'h1111 * (i + 1));
      tick();
    end
    IN_VALID = 1'b0;
    chk("fill_o0", 32'(O0), 32'h1111);
    chk("fill_o1", 32'(O1), 32'h2222);
    chk("fill_o2", 32'(O2), 32'h3333);
    chk("fill_o3", 32'(O3), 32'h4444);
    chk("fill_v", 32'(V), 32'hF);
    chk("fill_cnt", 32'(XFER_CNT), 32'd4);
    IN_VALID = 1'b1; S = 2'd1; D = 16'h5555;
    #1;
    chk("full_ready", 32'(IN_READY), 32'h0);
    tick();
    chk("full_o1", 32'(O1), 32'h2222);
    chk("full_cnt", 32'(XFER_CNT), 32'd4);
    IN_VALID = 1'b0;
    #1;
    chk("full_ready_novalid", 32'(IN_READY), 32'h0);
    ACK = 4'b0100; IN_VALID = 1'b1; S = 2'd2; D = 16'hA5A5;
    #1;
    chk("refill_ready", 32'(IN_READY), 32'h1);
    tick();
    chk("refill_o2", 32'(O2), 32'hA5A5);
    chk("refill_v", 32'(V), 32'hF);
    chk("refill_cnt", 32'(XFER_CNT), 32'd5);
    IN_VALID = 1'b0; ACK = 4'b1011;
    tick();
    chk("pre_bc_v", 32'(V), 32'h4);
    ACK = 4'b0000; BCAST = 1'b1; IN_VALID = 1'b1; D = 16'h00FF; S = 2'd0;
    #1;
    chk("bc_block_ready", 32'(IN_READY), 32'h0);
    tick();
    chk("bc_block_v", 32'(V), 32'h4);
    chk("bc_block_cnt", 32'(XFER_CNT), 32'd5);
    chk("bc_block_o0", 32'(O0), 32'h1111);
    ACK = 4'b0100;
    #1;
    chk("bc_ready", 32'(IN_READY), 32'h1);
    tick();
    chk("bc_o0", 32'(O0), 32'h00FF);
    chk("bc_o1", 32'(O1), 32'h00FF);
    chk("bc_o2", 32'(O2), 32'h00FF);
    chk("bc_o3", 32'(O3), 32'h00FF);
    chk("bc_v", 32'(V), 32'hF);
    chk("bc_cnt", 32'(XFER_CNT), 32'd6);
    BCAST = 1'b0; IN_VALID = 1'b0; ACK = 4'b1010;
    tick();
    chk("pop_v", 32'(V), 32'h5);
    chk("pop_o1", 32'(O1), 32'h00FF);
    chk("pop_o3", 32'(O3), 32'h00FF);
    chk("pop_cnt", 32'(XFER_CNT), 32'd6);
    tick();
    chk("pop_empty_v", 32'(V), 32'h5);
    ACK = 4'b0000;
    vm = 4'b0101;
    cm = 16'd6;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 64; k++) begin
        sv = 2'(s);
        dv = 16'(k * 1031) ^ {sv, 14'h2A5};
        am = 4'($urandom);
        am[sv] = 1'b1;
        ACK = am; IN_VALID = 1'b1; S = sv; D = dv;
        #1;
        chk("x_ready", 32'(IN_READY), 32'h1);
        tick();
        vm = (vm & ~am);
        vm[sv] = 1'b1;
        cm = cm + 16'd1;
        chk("x_o", 32'(o[sv]), 32'(dv));
        chk("x_v", 32'(V), 32'(vm));
      end
    end
    chk("x_cnt", 32'(XFER_CNT), 32'(cm));
    ACK = 4'b0001; IN_VALID = 1'b1; S = 2'd0; BCAST = 1'b0; D = 16'h1234;
    repeat (int'(16'hFFFF - cm)) @(posedge CLK);
    #1;
    chk("wrap_max", 32'(XFER_CNT), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(XFER_CNT), 32'h0);
    IN_VALID = 1'b0; ACK = 4'b0000;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
